leaf_out_arbiter: RTL and testbench

//  Round-robin arbiter sharing one leaf_interface output port (din_leaf_user2interface)

---
 rtl/leaf_out_arbiter_pkg.sv | 18 +
 rtl/leaf_rr_picker.sv | 29 ++
 rtl/leaf_out_arbiter.sv | 125 ++++++++++++
 tb/tb_leaf_out_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_out_arbiter_pkg.sv
// rtl/leaf_out_arbiter_pkg.sv - shared state encoding, defaults and index helper for the leaf output arbiter
package leaf_out_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_PAYLOAD_BITS = 32;
    localparam int DEF_MAX_BURST    = 16;

    // Inputs never exceed 2*n-2, so a single conditional subtract is enough.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/leaf_rr_picker.sv
// rtl/leaf_rr_picker.sv - combinational round-robin picker: first requester at or after rr_ptr
module leaf_rr_picker
    import leaf_out_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int IDX_BITS = 2
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [IDX_BITS-1:0] rr_ptr_i,
    output logic                any_o,
    output logic [IDX_BITS-1:0] winner_o
);

    // Scan from the far end so the requester closest to rr_ptr overrides.
    always_comb begin
        int idx;
        idx      = 0;
        any_o    = 1'b0;
        winner_o = rr_ptr_i;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = rr_wrap(int'(rr_ptr_i) + k, NUM_REQ);
            if (req_i[idx]) begin
                any_o    = 1'b1;
                winner_o = IDX_BITS'(idx);
            end
        end
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// rtl/leaf_out_arbiter.sv - packet-locked round-robin arbiter feeding one registered leaf output port
module leaf_out_arbiter
    import leaf_out_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
    parameter int MAX_BURST    = DEF_MAX_BURST,
    parameter int IDX_BITS     = 2,
    parameter int CNT_BITS     = 5
) (
    input  logic                            clk_user,
    input  logic                            reset,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_user2arb,
    input  logic [NUM_REQ-1:0]              vld_user2arb,
    input  logic [NUM_REQ-1:0]              last_user2arb,
    output logic [NUM_REQ-1:0]              ack_arb2user,
    output logic [PAYLOAD_BITS-1:0]         din_leaf_user2interface,
    output logic                            vld_user2interface,
    input  logic                            ack_interface2user,
    output logic [IDX_BITS-1:0]             grant_id,
    output logic                            busy
);

    arb_state_e              state_q;
    logic [IDX_BITS-1:0]     rr_ptr_q;
    logic [IDX_BITS-1:0]     grant_q;
    logic [CNT_BITS-1:0]     beat_cnt_q;
    logic                    out_vld_q;
    logic                    out_vld_d;
    logic [PAYLOAD_BITS-1:0] out_data_q;
    logic [PAYLOAD_BITS-1:0] out_data_d;

    logic                    pick_any;
    logic [IDX_BITS-1:0]     pick_idx;
    logic                    can_load;
    logic                    grant_vld;
    logic                    grant_last;
    logic [PAYLOAD_BITS-1:0] grant_din;
    logic                    accept;
    logic                    release_grant;
    logic [IDX_BITS-1:0]     next_ptr;

    leaf_rr_picker #(
        .NUM_REQ  (NUM_REQ),
        .IDX_BITS (IDX_BITS)
    ) u_picker (
        .req_i    (vld_user2arb),
        .rr_ptr_i (rr_ptr_q),
        .any_o    (pick_any),
        .winner_o (pick_idx)
    );

    // The output stage can take a beat when empty or draining this cycle.
    always_comb begin
        can_load      = !out_vld_q || ack_interface2user;
        grant_vld     = vld_user2arb[grant_q];
        grant_last    = last_user2arb[grant_q];
        grant_din     = din_user2arb[int'(grant_q)*PAYLOAD_BITS +: PAYLOAD_BITS];
        accept        = (state_q == ARB_LOCK) && can_load && grant_vld;
        release_grant = accept && (grant_last || (beat_cnt_q == CNT_BITS'(MAX_BURST - 1)));
        next_ptr      = (grant_q == IDX_BITS'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

        ack_arb2user = '0;
        if (state_q == ARB_LOCK) begin
            ack_arb2user[grant_q] = can_load;
        end
    end

    always_ff @(posedge clk_user) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_q    <= pick_idx;
                        beat_cnt_q <= '0;
                        state_q    <= ARB_LOCK;
                    end
                end
                ARB_LOCK: begin
                    if (accept) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (release_grant) begin
                            state_q  <= ARB_IDLE;
                            rr_ptr_q <= next_ptr;
                        end
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // A load in the same cycle as a drain keeps the stage full with the new beat.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        if (accept) begin
            out_vld_d  = 1'b1;
            out_data_d = grant_din;
        end else if (ack_interface2user) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_user) begin
        if (reset) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

    assign vld_user2interface      = out_vld_q;
    assign din_leaf_user2interface = out_data_q;
    assign grant_id                = grant_q;
    assign busy                    = (state_q == ARB_LOCK);

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// tb/tb_leaf_out_arbiter.sv - scoreboard bench for leaf_out_arbiter with queued producer models
module tb_leaf_out_arbiter;

    localparam int NR = 4;
    localparam int PB = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NR*PB-1:0] din = '0;
    logic [NR-1:0]    vld = '0;
    logic [NR-1:0]    last = '0;
    logic [NR-1:0]    ack;
    logic [PB-1:0]    dout;
    logic             vout;
    logic             ack_if = 1'b1;
    logic [1:0]       gid;
    logic             busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [PB:0]   pq [NR][$];
    logic [PB-1:0] exp_q [$];
    int            out_cyc [$];
    logic [NR-1:0] xfer = '0;
    logic          sink_ready = 1'b1;
    logic          rst_req = 1'b1;
    logic [PB-1:0] held;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    leaf_out_arbiter dut (
        .clk_user                (clk),
        .reset                   (reset),
        .din_user2arb            (din),
        .vld_user2arb            (vld),
        .last_user2arb           (last),
        .ack_arb2user            (ack),
        .din_leaf_user2interface (dout),
        .vld_user2interface      (vout),
        .ack_interface2user      (ack_if),
        .grant_id                (gid),
        .busy                    (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (vout && ack_if) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%0h required=none", dout);
            end else begin
                check("out_beat", dout, exp_q.pop_front());
            end
            out_cyc.push_back(cyc);
        end
    end

    task automatic cycle();
        logic [PB:0] h;
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            if (xfer[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        end
        xfer = '0;
        for (int i = 0; i < NR; i++) begin
            if (pq[i].size() > 0) begin
                h = pq[i][0];
                vld[i] = 1'b1;
                last[i] = h[PB];
                din[i*PB +: PB] = h[PB-1:0];
            end else begin
                vld[i] = 1'b0;
                last[i] = 1'b0;
                din[i*PB +: PB] = '0;
            end
        end
        ack_if = sink_ready;
        reset = rst_req;
        #1;
        xfer = vld & ack;
        #1;
    endtask

    task automatic flush();
        for (int i = 0; i < NR; i++) pq[i].delete();
        exp_q.delete();
        out_cyc.delete();
        xfer = '0;
    endtask

    task automatic add_beat(input int p, input logic [PB-1:0] d, input logic l, input logic e);
        pq[p].push_back({l, d});
        if (e) exp_q.push_back(d);
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        sink_ready = 1'b1;
        flush();
        cycle();
        cycle();
        rst_req = 1'b0;
        flush();
        cycle();
    endtask

    task automatic run(input int budget, input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain actual=%0d required=0 beats pending", name, exp_q.size());
        end
    endtask

    task automatic wait_outputs(input int count, input int budget, input string name);
        int n = 0;
        while (out_cyc.size() < count && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (out_cyc.size() < count) begin
            failures++;
            $display("FAIL %s_wait actual=%0d required=%0d outputs", name, out_cyc.size(), count);
        end
    endtask

    task automatic check_gaps(input string name, input int gap, input int count);
        check({name, "_count"}, out_cyc.size(), count);
        for (int i = 1; i < out_cyc.size(); i++) begin
            check(name, out_cyc[i] - out_cyc[i-1], gap);
        end
    endtask

    initial begin
        // reset state
        do_reset();
        check("rst_vld", vout, 0);
        check("rst_data", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", gid, 0);
        check("rst_ack", ack, 0);

        // 1: lone producer 2, three beats, one arbitration bubble
        add_beat(2, 32'h2000_000A, 1'b0, 1'b1);
        add_beat(2, 32'h2000_000B, 1'b0, 1'b1);
        add_beat(2, 32'h2000_000C, 1'b1, 1'b1);
        cycle();
        check("t1_bubble_busy", busy, 0);
        check("t1_bubble_ack", ack, 4'b0000);
        cycle();
        check("t1_lock_busy", busy, 1);
        check("t1_grant", gid, 2);
        check("t1_lock_ack", ack, 4'b0100);
        run(20, "t1");
        check_gaps("t1_gap", 1, 3);
        check("t1_release_busy", busy, 0);
        check("t1_grant_hold", gid, 2);

        // 2: everyone requests single-beat packets -> 0,1,2,3,0,1,2,3
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NR; p++)
                pq[p].push_back({1'b1, 32'h3000_0000 + 32'(p * 16 + r)});
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NR; p++)
                exp_q.push_back(32'h3000_0000 + 32'(p * 16 + r));
        run(60, "t2");
        check_gaps("t2_gap", 2, 8);

        // 3: 40-beat stream from producer 1 is cut at 16 beats, producer 2 slips in
        do_reset();
        for (int k = 0; k < 40; k++) add_beat(1, 32'h1100_0000 + 32'(k), 1'b0, 1'b0);
        add_beat(2, 32'h2200_0001, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) exp_q.push_back(32'h1100_0000 + 32'(k));
        exp_q.push_back(32'h2200_0001);
        for (int k = 16; k < 40; k++) exp_q.push_back(32'h1100_0000 + 32'(k));
        run(200, "t3");
        check("t3_total", out_cyc.size(), 41);
        check("t3_p1_left", pq[1].size(), 0);
        check("t3_busy_held", busy, 1);
        check("t3_grant_held", gid, 1);

        // 4: sink stalls five cycles mid-burst
        do_reset();
        for (int k = 0; k < 8; k++) add_beat(0, 32'h4000_0000 + 32'(k), k == 7, 1'b1);
        wait_outputs(2, 20, "t4");
        sink_ready = 1'b0;
        cycle();
        held = dout;
        check("t4_held_data", held, 32'h4000_0002);
        check("t4_stall_ack", ack, 4'b0000);
        for (int s = 0; s < 4; s++) begin
            cycle();
            check("t4_stall_data", dout, 32'h4000_0002);
            check("t4_stall_vld", vout, 1);
            check("t4_stall_ack", ack, 4'b0000);
        end
        sink_ready = 1'b1;
        cycle();
        check("t4_resume_ack", ack, 4'b0001);
        run(30, "t4");
        check("t4_total", out_cyc.size(), 8);

        // 5: reset at beat 2 of a 5-beat burst, then 0 and 3 compete
        do_reset();
        for (int k = 0; k < 5; k++) add_beat(1, 32'h5100_0000 + 32'(k), k == 4, 1'b1);
        wait_outputs(2, 20, "t5");
        rst_req = 1'b1;
        sink_ready = 1'b0;
        cycle();
        flush();
        rst_req = 1'b0;
        sink_ready = 1'b1;
        cycle();
        check("t5_vld", vout, 0);
        check("t5_data", dout, 0);
        check("t5_busy", busy, 0);
        check("t5_grant", gid, 0);
        check("t5_ack", ack, 0);
        add_beat(3, 32'h5300_0001, 1'b1, 1'b0);
        add_beat(0, 32'h5000_0001, 1'b1, 1'b0);
        exp_q.push_back(32'h5000_0001);
        exp_q.push_back(32'h5300_0001);
        run(20, "t5");

        // 6: drain and load in the same cycle keeps the stage full
        do_reset();
        for (int k = 0; k < 6; k++) add_beat(3, 32'h6300_0000 + 32'(k), k == 5, 1'b1);
        run(30, "t6");
        check_gaps("t6_gap", 1, 6);
        repeat (3) cycle();
        check("t6_end_vld", vout, 0);
        check("t6_end_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
